// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared VGA constants: the 640x480 @ 60 Hz timing set (sync-first
// coordinates, visible area hCount 144..783 / vCount 35..514) and the
// 12-bit RGB colour constants used by the game state machine and renderer.
package vga_timing_pkg;

    localparam int CNT_W           = 10;

    localparam int DEF_CLK_DIV     = 4;    // 100 MHz -> 25 MHz pixel rate
    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_VIS_START = 144;
    localparam int DEF_H_VIS_END   = 784;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_VIS_START = 35;
    localparam int DEF_V_VIS_END   = 515;

    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
    localparam logic [11:0] COLOR_RED    = 12'hF00;
    localparam logic [11:0] COLOR_GREEN  = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE   = 12'h00F;
    localparam logic [11:0] COLOR_YELLOW = 12'hFF0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Raster timing bundle from the generator (master) to its consumers (slave).
//   hCount/vCount : current raster position (sync-first coordinates)
//   bright        : position is inside the visible window
//   hSync/vSync   : active-low sync pins
//   pix_en        : one-clock pixel strobe
//   frame_tick    : one-clock pulse as the last visible line ends
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             bright;
    logic             hSync;
    logic             vSync;
    logic             pix_en;
    logic             frame_tick;

    modport master (
        output hCount, vCount, bright, hSync, vSync, pix_en, frame_tick
    );

    modport slave (
        input  hCount, vCount, bright, hSync, vSync, pix_en, frame_tick
    );
endinterface

// File: rtl/pixel_enable_gen.sv
// pixel_enable_gen
// Divides the system clock down to a pixel strobe.
//   clk      : system clock
//   rst      : synchronous active-low reset
//   pix_en_o : high for one clock every CLK_DIV clocks (when div == CLK_DIV-1)
module pixel_enable_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    assign pix_en_o = (div_q == DIV_MAX);

    always_comb begin
        div_d = pix_en_o ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) div_q <= '0;
        else      div_q <= div_d;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480 @ 60 Hz raster timing from the 100 MHz board clock.
//   clk : system clock
//   rst : synchronous active-low reset
//   vga : master modport -- hCount, vCount, bright, hSync, vSync, pix_en,
//         frame_tick. Decodes are combinational from the count registers,
//         so they line up with hCount/vCount with no extra latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_VIS_START = DEF_H_VIS_START,
    parameter int H_VIS_END   = DEF_H_VIS_END,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_VIS_START = DEF_V_VIS_START,
    parameter int V_VIS_END   = DEF_V_VIS_END
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   vga
);
    localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SW    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SW    = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VS    = CNT_W'(H_VIS_START);
    localparam logic [CNT_W-1:0] H_VE    = CNT_W'(H_VIS_END);
    localparam logic [CNT_W-1:0] V_VS    = CNT_W'(V_VIS_START);
    localparam logic [CNT_W-1:0] V_VE    = CNT_W'(V_VIS_END);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_VIS_END - 1);

    logic             pix_en;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    pixel_enable_gen #(.CLK_DIV(CLK_DIV)) u_pix_en (
        .clk      (clk),
        .rst      (rst),
        .pix_en_o (pix_en)
    );

    // vCount only moves when hCount wraps; both wrap together at the
    // bottom-right corner.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign vga.hCount     = h_q;
    assign vga.vCount     = v_q;
    assign vga.pix_en     = pix_en;
    assign vga.hSync      = !(h_q < H_SW);
    assign vga.vSync      = !(v_q < V_SW);
    assign vga.bright     = (h_q >= H_VS) && (h_q < H_VE) &&
                            (v_q >= V_VS) && (v_q < V_VE);
    // Pulses on the strobe that ends the last visible line, giving game
    // logic the whole vertical blanking interval to update positions.
    assign vga.frame_tick = pix_en && (h_q == H_MAX) && (v_q == V_LAST);
endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    // Instance A: default 640x480 timing.
    // Instance B: default horizontal timing, short frame (6 lines, visible
    // lines 3..4, vSync lines 0..1) so frame-level behaviour fits in a short run.
    localparam int TMO = 40000;

    logic clk;
    logic rst_a, rst_b;
    int   cyc;
    int   checks;
    int   errors;
    int   t0;
    int   bad;
    int   lows;

    vga_timing_gen_if va ();
    vga_timing_gen_if vb ();

    vga_timing_gen dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (va)
    );

    vga_timing_gen #(
        .CLK_DIV     (4),
        .H_TOTAL     (800),
        .H_SYNC      (96),
        .H_VIS_START (144),
        .H_VIS_END   (784),
        .V_TOTAL     (6),
        .V_SYNC      (2),
        .V_VIS_START (3),
        .V_VIS_END   (5)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (vb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the first sample at (h,v) on instance B (optionally with
    // pix_en high); a timeout counts as a failed check.
    task automatic wait_b(input int h, input int v, input bit pe, input string tag);
        int n;
        n = 0;
        while (!(int'(vb.hCount) == h && int'(vb.vCount) == v && (!pe || vb.pix_en)) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, int'(n < TMO), 1);
    endtask

    task automatic wait_tick_b(input string tag);
        int n;
        n = 0;
        while (!vb.frame_tick && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, int'(n < TMO), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a  = 1'b0;
        rst_b  = 1'b0;

        // Reset values
        step(5);
        chk("rst_hCount",     int'(va.hCount),     0);
        chk("rst_vCount",     int'(va.vCount),     0);
        chk("rst_bright",     int'(va.bright),     0);
        chk("rst_hSync",      int'(va.hSync),      0);
        chk("rst_vSync",      int'(va.vSync),      0);
        chk("rst_pix_en",     int'(va.pix_en),     0);
        chk("rst_frame_tick", int'(va.frame_tick), 0);

        // Pixel strobe cadence: pix_en at edges 3,7; hCount 1 at 4, 2 at 8
        rst_a = 1'b1;
        step(2);
        chk("e2_pix_en",  int'(va.pix_en), 0);
        step(1);
        chk("e3_pix_en",  int'(va.pix_en), 1);
        chk("e3_hCount",  int'(va.hCount), 0);
        step(1);
        chk("e4_pix_en",  int'(va.pix_en), 0);
        chk("e4_hCount",  int'(va.hCount), 1);
        step(3);
        chk("e7_pix_en",  int'(va.pix_en), 1);
        step(1);
        chk("e8_hCount",  int'(va.hCount), 2);

        // Line wrap: edge 3199 is the last strobe of line 0
        step(3191);
        chk("e3199_hCount", int'(va.hCount), 799);
        chk("e3199_vCount", int'(va.vCount), 0);
        chk("e3199_pix_en", int'(va.pix_en), 1);
        step(1);
        chk("e3200_hCount", int'(va.hCount), 0);
        chk("e3200_vCount", int'(va.vCount), 1);
        chk("line1_vSync",  int'(va.vSync),  0);

        // hSync over one full line
        bad  = 0;
        lows = 0;
        for (int i = 0; i < 3200; i++) begin
            if (va.hSync !== (va.hCount >= 10'd96)) bad++;
            if (va.hSync === 1'b0) lows++;
            step(1);
        end
        chk("hsync_pattern_errs", bad,  0);
        chk("hsync_low_clocks",   lows, 384);
        chk("line2_hCount", int'(va.hCount), 0);
        chk("line2_vCount", int'(va.vCount), 2);
        chk("line2_vSync",  int'(va.vSync),  1);

        // Instance B: visible-window corners
        rst_b = 1'b1;
        chk("b_start_vSync", int'(vb.vSync), 0);
        wait_b(144, 2, 1'b0, "b_144_2");
        chk("b_144_2_bright", int'(vb.bright), 0);
        chk("b_144_2_vSync",  int'(vb.vSync),  1);
        wait_b(143, 3, 1'b0, "b_143_3");
        chk("b_143_3_bright", int'(vb.bright), 0);
        wait_b(144, 3, 1'b0, "b_144_3");
        chk("b_144_3_bright", int'(vb.bright), 1);
        wait_b(783, 3, 1'b0, "b_783_3");
        chk("b_783_3_bright", int'(vb.bright), 1);
        wait_b(784, 3, 1'b0, "b_784_3");
        chk("b_784_3_bright", int'(vb.bright), 0);
        wait_b(144, 4, 1'b0, "b_144_4");
        chk("b_144_4_bright", int'(vb.bright), 1);
        wait_b(783, 4, 1'b0, "b_783_4");
        chk("b_783_4_bright", int'(vb.bright), 1);

        // Frame tick at the end of the last visible line
        wait_tick_b("b_tick1");
        t0 = cyc;
        chk("tick1_hCount", int'(vb.hCount), 799);
        chk("tick1_vCount", int'(vb.vCount), 4);
        step(1);
        chk("tick1_width",     int'(vb.frame_tick), 0);
        chk("after_tick_vCount", int'(vb.vCount),   5);
        wait_b(144, 5, 1'b0, "b_144_5");
        chk("b_144_5_bright", int'(vb.bright), 0);

        // Simultaneous wrap of both counters
        wait_b(799, 5, 1'b1, "b_corner");
        step(1);
        chk("wrap_hCount", int'(vb.hCount), 0);
        chk("wrap_vCount", int'(vb.vCount), 0);
        chk("wrap_vSync",  int'(vb.vSync),  0);

        // Frame period: 800 * 4 * 6 clocks
        wait_tick_b("b_tick2");
        chk("frame_period", cyc - t0, 19200);

        // Mid-frame reset with div=2
        wait_b(400, 3, 1'b0, "b_400_3");
        step(2);
        chk("pre_rst_hCount", int'(vb.hCount), 400);
        rst_b = 1'b0;
        step(1);
        chk("midrst_hCount", int'(vb.hCount), 0);
        chk("midrst_vCount", int'(vb.vCount), 0);
        chk("midrst_pix_en", int'(vb.pix_en), 0);
        rst_b = 1'b1;
        step(2);
        chk("rel2_pix_en", int'(vb.pix_en), 0);
        step(1);
        chk("rel3_pix_en", int'(vb.pix_en), 1);
        chk("rel3_hCount", int'(vb.hCount), 0);
        step(1);
        chk("rel4_hCount", int'(vb.hCount), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
